// File: rtl/pp_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pp_mult_sequencer
//  Description : Sequential shift-add multiplier controller. Reuses a single
//                WIDTH-bit partial-product row adder over WIDTH cycles to
//                form the unsigned 2*WIDTH-bit product A*B. Operands are
//                captured on an accepted start, one multiplier bit is
//                consumed per cycle, and the product is presented on P
//                together with a one-cycle done pulse.
//  Options     : define ZERO_SKIP_EN to bypass RUN when A or B is zero
//                (done then pulses in the cycle after the start edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_mult_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    // Counter wide enough to reach WIDTH-1 (log2(WIDTH) bits).
    localparam int             CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_acc_hi;
    logic [WIDTH-1:0]       r_mq;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_p;

    logic                   w_accept;
    logic                   w_zero_skip;
    logic                   w_last;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_shift;

    // A new operation can only be taken while not running.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef ZERO_SKIP_EN
    // A zero operand makes the product trivially zero, so RUN is bypassed.
    assign w_zero_skip = (A == '0) || (B == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    assign w_last = (r_state == S_RUN) && (r_cnt == CNT_LAST);

    // Row adder: add the multiplicand when the current multiplier bit is set.
    // The sum is one bit wider so the carry out survives into the shift.
    assign w_addend = r_mq[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_addend};
    assign w_shift  = {w_sum, r_mq[WIDTH-1:1]};

    assign P = r_p;

    // State register; reset aborts any run in progress.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the state-derived status outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_zero_skip ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next_state = w_zero_skip ? S_DONE : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one shift-add step per RUN cycle, and the
    // product register which only changes on the final step (or a skip).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_mq     <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= A;
            r_mq     <= B;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            if (w_zero_skip) begin
                r_p <= '0;
            end
        end else if (r_state == S_RUN) begin
            {r_acc_hi, r_mq} <= w_shift;
            r_cnt            <= r_cnt + CNT_ONE;
            if (w_last) begin
                r_p <= w_shift;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pp_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_mult_sequencer
//  Description : Self-checking bench for pp_mult_sequencer. Expected
//                products and latencies come from plain arithmetic on the
//                operands (A*B, WIDTH+1 cycles or 1 cycle on zero skip).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_mult_sequencer;

    localparam int W = 4;
`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic             Clock;
    logic             Reset;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   P;

    int total;
    int bad;

    pp_mult_sequencer #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: cycles from accept edge to done, and busy cycles.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (ZS && ((a == 0) || (b == 0))) return 1;
        return W + 1;
    endfunction

    function automatic int exp_busy(input logic [W-1:0] a, input logic [W-1:0] b);
        if (ZS && ((a == 0) || (b == 0))) return 0;
        return W;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issue one operation and measure it; no checking here.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy,
                          output logic [2*W-1:0] p);
        int  c;
        bit  seen;
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a; B = ~b;            // captured copies must be used
        lat = -1; nbusy = 0; seen = 1'b0; c = 1;
        while (!seen && c <= 4 * W + 8) begin
            if (busy) nbusy++;
            if (done) begin
                lat  = c;
                seen = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        p = P;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; A = '0; B = '0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (P !== '0) begin bad++; $display("FAIL reset_P got=%0d want=0", P); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, nb; logic [2*W-1:0] p;
        run_op(4'd13, 4'd11, lat, nb, p);
        total++; if (lat != exp_lat(13, 11)) begin bad++; $display("FAIL basic_lat got=%0d want=%0d", lat, exp_lat(13, 11)); end
        total++; if (nb != exp_busy(13, 11)) begin bad++; $display("FAIL basic_busy got=%0d want=%0d", nb, exp_busy(13, 11)); end
        total++; if (p !== 8'(13 * 11)) begin bad++; $display("FAIL basic_P got=%0d want=%0d", p, 13 * 11); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_drop got=%b want=0", done); end
        total++; if (P !== 8'(13 * 11)) begin bad++; $display("FAIL basic_P_hold got=%0d want=%0d", P, 13 * 11); end
    endtask

    task automatic test_carry();
        int lat, nb; logic [2*W-1:0] p;
        logic [W-1:0] ta [3] = '{4'd15, 4'd1, 4'd8};
        logic [W-1:0] tb [3] = '{4'd15, 4'd1, 4'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat, nb, p);
            total++; if (p !== 8'(int'(ta[i]) * int'(tb[i]))) begin bad++; $display("FAIL carry_P[%0d] got=%0d want=%0d", i, p, int'(ta[i]) * int'(tb[i])); end
            total++; if (lat != exp_lat(ta[i], tb[i])) begin bad++; $display("FAIL carry_lat[%0d] got=%0d want=%0d", i, lat, exp_lat(ta[i], tb[i])); end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int c; int extra; bit seen;
        A = 4'd7; B = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;                 // run cycle 1
        tick();                       // run cycle 2
        A = 4'd2; B = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        c = 3; seen = 1'b0;
        while (!seen && c <= 4 * W) begin
            if (done) seen = 1'b1; else begin tick(); c++; end
        end
        total++; if (c != W + 1) begin bad++; $display("FAIL ignore_lat got=%0d want=%0d", c, W + 1); end
        total++; if (P !== 8'd63) begin bad++; $display("FAIL ignore_P got=%0d want=63", P); end
        extra = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            tick();
            if (done) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL ignore_second_done got=%0d want=0", extra); end
    endtask

    task automatic test_back_to_back();
        int c; bit seen;
        A = 4'd5; B = 4'd6; start = 1'b1;
        tick();
        c = 1; seen = 1'b0;
        while (!seen && c <= 4 * W) begin
            if (done) seen = 1'b1; else begin tick(); c++; end
        end
        total++; if (c != W + 1) begin bad++; $display("FAIL b2b_lat1 got=%0d want=%0d", c, W + 1); end
        total++; if (P !== 8'd30) begin bad++; $display("FAIL b2b_P1 got=%0d want=30", P); end
        A = 4'd3; B = 4'd4;           // start still held through DONE
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_idle got=%b want=1", busy); end
        start = 1'b0;
        c = 1; seen = 1'b0;
        while (!seen && c <= 4 * W) begin
            if (done) seen = 1'b1; else begin tick(); c++; end
        end
        total++; if (c != W + 1) begin bad++; $display("FAIL b2b_lat2 got=%0d want=%0d", c, W + 1); end
        total++; if (P !== 8'd12) begin bad++; $display("FAIL b2b_P2 got=%0d want=12", P); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int dones;
        A = 4'd9; B = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;                 // run cycle 1
        tick();                       // run cycle 2
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        total++; if (P !== '0) begin bad++; $display("FAIL midrst_P got=%0d want=0", P); end
        dones = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            tick();
            if (done || busy) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midrst_activity got=%0d want=0", dones); end
    endtask

    task automatic test_zero();
        int lat, nb; logic [2*W-1:0] p;
        // Put a nonzero product in P first so a zero result is observable.
        run_op(4'd3, 4'd3, lat, nb, p);
        tick();
        run_op(4'd0, 4'd12, lat, nb, p);
        total++; if (p !== '0) begin bad++; $display("FAIL zero_P got=%0d want=0", p); end
        total++; if (lat != exp_lat(0, 12)) begin bad++; $display("FAIL zero_lat got=%0d want=%0d", lat, exp_lat(0, 12)); end
        total++; if (nb != exp_busy(0, 12)) begin bad++; $display("FAIL zero_busy got=%0d want=%0d", nb, exp_busy(0, 12)); end
        tick();
    endtask

    task automatic test_random();
        int lat, nb; logic [2*W-1:0] p;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            run_op(a, b, lat, nb, p);
            total++; if (p !== 8'(int'(a) * int'(b))) begin bad++; $display("FAIL rand_P[%0d] a=%0d b=%0d got=%0d want=%0d", i, a, b, p, int'(a) * int'(b)); end
            total++; if (lat != exp_lat(a, b)) begin bad++; $display("FAIL rand_lat[%0d] got=%0d want=%0d", i, lat, exp_lat(a, b)); end
            total++; if (nb != exp_busy(a, b)) begin bad++; $display("FAIL rand_busy[%0d] got=%0d want=%0d", i, nb, exp_busy(a, b)); end
            if ($urandom_range(0, 1) == 1) tick();   // mix idle gaps and back-to-back
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pp_mult_sequencer.md
Name: pp_mult_sequencer

Overview:
Sequential shift-add multiplier controller. It sequences one WIDTH-bit partial-product row adder over WIDTH cycles instead of instantiating WIDTH rows. It accepts operands on a start strobe, runs one multiplier bit per cycle, and returns the 2*WIDTH-bit product with a one-cycle done pulse. It sits between a requesting FSM (or user I/O) and the shared row-adder datapath.

Parameters:
WIDTH, 4, operand width in bits (multiplicand A and multiplier B); legal range 2..16.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
start  input  1  request strobe; sampled only in IDLE or DONE.
A  input  WIDTH  multiplicand; captured when start is accepted.
B  input  WIDTH  multiplier; captured when start is accepted.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; P is valid on this cycle.
P  output  2*WIDTH  product register; holds its value until the next accepted start.

Behaviour:
- Reset (synchronous, Reset=1 at the edge): state=IDLE, busy=0, done=0, P=0, internal accumulator/multiplier/count=0. Reset takes priority over every other event, including mid-RUN. A run in progress is aborted and no done is issued.
- Internal registers:
  - mcand[WIDTH-1:0].
  - acc_hi[WIDTH-1:0] (upper partial product).
  - mq[WIDTH-1:0] (multiplier, shifted right; receives low product bits).
  - cnt[log2(WIDTH) bits].
- State IDLE: busy=0, done=0.
  - If start=1: mcand<=A, mq<=B, acc_hi<=0, cnt<=0, next state RUN.
  - Otherwise stay in IDLE.
- State RUN: busy=1.
  - Each cycle: {c,s} = acc_hi + (mq[0] ? mcand : 0), a (WIDTH+1)-bit sum with carry-out c. This is the row-adder operation with carry-in 0.
  - Then {acc_hi,mq} <= {c,s,mq[WIDTH-1:1]}, a right shift that includes the carry.
  - cnt<=cnt+1. When cnt==WIDTH-1, next state is DONE and P <= the final shifted {acc_hi,mq} on that same edge.
  - start is ignored in RUN: no queueing and no restart.
- State DONE: done=1 for exactly one cycle, busy=0, P valid.
  - If start=1: accept the new operands as in IDLE and go to RUN (back-to-back operation; no idle bubble required).
  - Otherwise go to IDLE.
- Latency: start accepted at edge t; RUN occupies cycles t+1..t+WIDTH; done=1 in cycle t+WIDTH+1.
- Throughput: one product per WIDTH+1 cycles.
- Arithmetic: unsigned only. P = A*B exactly, with no overflow possible since 2*WIDTH bits suffice. The carry out of the row add must be retained; dropping it is a bug (e.g. 15*15).
- A and B may change freely after acceptance; only the captured copies are used.
- P is not cleared at the start of a new run. It updates only on the final RUN edge.

Optional Feature:
ZERO_SKIP_EN
- Defined: when start is accepted with A==0 or B==0, the block skips RUN. The next state is DONE, P<=0, and done pulses in cycle t+1. busy is never asserted for that operation.
- Not defined: zero operands take the full WIDTH-cycle RUN like any other operands, with done at t+WIDTH+1.
- Non-zero operands behave identically in both builds.

Test Plan:
1. WIDTH=4, Reset 2 cycles, then A=13, B=11, start 1 cycle -> busy=1 for exactly 4 cycles; done=1 on the 5th cycle after the start edge; P=143 (0x8F); done low again the next cycle; P holds 0x8F.
2. A=15, B=15 -> P=225 (0xE1). This checks carry retention; then A=1,B=1 -> P=1; A=8,B=0 -> P=0 (full latency unless ZERO_SKIP_EN).
3. Start A=7,B=9; pulse start again with A=2,B=2 during RUN -> the second start is ignored; P=63 after the first done; no second done follows.
4. Back-to-back: A=5,B=6 with start held high through the DONE cycle, A/B changed to 3,4 at that cycle -> first done gives P=30; the second run is accepted with no IDLE cycle; the second done comes 5 cycles later with P=12.
5. Start A=9,B=9; assert Reset in the 2nd RUN cycle -> next cycle state is IDLE, busy=0, done=0, P=0; no done pulse ever appears for that run.
6. ZERO_SKIP_EN defined, A=0,B=12 -> done=1 in the cycle after the start edge, busy never 1, P=0. Without the macro -> done at cycle 5, P=0.
